// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// A grant lasts one burst, bounded by req_last, MAX_BURST beats or almost-full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int MAX_BURST  = 8
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_enable,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [DATA_WIDTH-1:0]         wr_mask,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [BCW-1:0] beat_cnt;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic           xfer;
    logic           beat_end;

    // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    assign xfer     = (state == BURST) & req_valid[grant_id] & fifo_enable & ~fifo_full;
    assign beat_end = req_last[grant_id] | (beat_cnt == BCW'(MAX_BURST - 1)) | fifo_almost_full;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
        wr_en   = xfer;
        wr_data = xfer ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
        wr_mask = {DATA_WIDTH{xfer}};
    end

    assign busy = (state == BURST);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state    <= ARB;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (fifo_enable && sel_found) begin
                        grant_id <= sel_idx;
                        rr_ptr   <= sel_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Stalls leave everything untouched; only a real transfer advances the burst.
                    if (xfer) begin
                        if (beat_end) begin
                            beat_cnt <= '0;
                            state    <= ARB;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner cases,
// and randomized traffic against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int MB = 8;
    localparam int IW = 2;

    logic              wr_clk = 1'b0;
    logic              wr_rst_n = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_enable = 1'b0;
    logic              fifo_full = 1'b0;
    logic              fifo_almost_full = 1'b0;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     wr_mask;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: whether a grant is open, who holds it, beats done, last winner
    bit m_busy;
    int m_gid;
    int m_ptr;
    int m_beats;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk(wr_clk),
        .wr_rst_n(wr_rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .fifo_enable(fifo_enable),
        .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          en;
        logic          full;
        logic          af;
        logic          exp_wr;
        logic [N-1:0]  exp_rdy;
        logic          exp_busy;
        logic [IW-1:0] exp_gid;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic e, input logic f, input logic a);
        req_valid        = v;
        req_last         = l;
        fifo_enable      = e;
        fifo_full        = f;
        fifo_almost_full = a;
    endtask

    function automatic logic model_xfer();
        return m_busy && req_valid[m_gid] && fifo_enable && !fifo_full;
    endfunction

    task automatic modelCheck(input string tag);
        logic          x;
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        x  = model_xfer();
        er = '0;
        ed = '0;
        if (x) begin
            er[m_gid] = 1'b1;
            ed = req_data[m_gid*DW +: DW];
        end
        checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'(x));
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'(er));
        checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'(ed));
        checkOutput({tag, "_wr_mask"}, 64'(wr_mask), 64'({DW{x}}));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(m_busy));
        checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'(m_gid));
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge
    task automatic tick();
        logic x;
        x = model_xfer();
        if (!m_busy) begin
            if (fifo_enable && req_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_gid = (m_ptr + k) % N;
                        break;
                    end
                end
                m_ptr   = m_gid;
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (x) begin
            m_beats++;
            if (req_last[m_gid] || m_beats == MB || fifo_almost_full) m_busy = 1'b0;
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_ptr   = N - 1;
        m_beats = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'(0));
        checkOutput({tag, "_wr_mask"}, 64'(wr_mask), 64'(0));
    endtask

    task automatic doReset(input string tag);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        wr_rst_n = 1'b0;
        #1;
        checkResetOutputs(tag);
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int wr_cnt;
        int wi;
        logic hs;
        logic [DW-1:0] got_q[$];
        logic [N-1:0] rl;
        logic [N*DW-1:0] pattern;
        bit log_wr[45];
        int log_gid[45];

        pattern = {12'hD33, 12'hC22, 12'hB11, 12'hA00};
        vecs[0]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[7]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[9]  = '{4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[10] = '{4'b1001, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3};
        vecs[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[13] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};

        #2;
        $display("[TB] vector table");
        doReset("rst0");
        req_data = pattern;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].en, vecs[i].full, vecs[i].af);
            #3;
            checkOutput($sformatf("vec%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_rdy));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_grant_id", i), 64'(grant_id), 64'(vecs[i].exp_gid));
            checkOutput($sformatf("vec%0d_wr_mask", i), 64'(wr_mask), 64'({DW{vecs[i].exp_wr}}));
            if (vecs[i].exp_wr)
                checkOutput($sformatf("vec%0d_wr_data", i), 64'(wr_data),
                            64'(pattern[vecs[i].exp_gid*DW +: DW]));
            tick();
        end

        $display("[TB] all requesters continuously valid");
        doReset("rst1");
        req_data = (N*DW)'({$urandom(), $urandom()});
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        wr_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            #3;
            modelCheck($sformatf("rr_c%0d", c));
            log_wr[c]  = wr_en;
            log_gid[c] = int'(grant_id);
            if (wr_en) wr_cnt++;
            tick();
        end
        checkOutput("rr_total_writes", 64'(wr_cnt), 64'(40));
        for (int b = 0; b < 5; b++) begin
            checkOutput($sformatf("rr_burst%0d_gid", b), 64'(log_gid[1 + 9*b]), 64'(b % 4));
            if (b > 0) checkOutput($sformatf("rr_gap%0d_wr_en", b), 64'(log_wr[9*b]), 64'(0));
        end

        $display("[TB] fifo_full stall on requester 1");
        doReset("rst2");
        wi = 0;
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            applyStimulus((wi < 8) ? 4'b0010 : 4'b0000, 4'b0000, 1'b1, (c >= 3 && c <= 7), 1'b0);
            req_data = '0;
            req_data[DW +: DW] = DW'(12'h100 + wi);
            #3;
            modelCheck($sformatf("full_c%0d", c));
            if (c >= 3 && c <= 7) checkOutput($sformatf("full_c%0d_stalled", c), 64'(wr_en), 64'(0));
            if (wr_en) got_q.push_back(wr_data);
            hs = req_ready[1];
            tick();
            if (hs) wi++;
        end
        checkOutput("full_total_writes", 64'(got_q.size()), 64'(8));
        for (int k = 0; k < got_q.size() && k < 8; k++)
            checkOutput($sformatf("full_word%0d", k), 64'(got_q[k]), 64'(12'h100 + k));

        $display("[TB] almost_full ends burst of requester 2");
        doReset("rst3");
        req_data = (N*DW)'({$urandom(), $urandom()});
        wr_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(4'b1100, 4'b0000, 1'b1, 1'b0, (c == 3));
            #3;
            modelCheck($sformatf("af_c%0d", c));
            if (wr_en && grant_id == 2'd2) wr_cnt++;
            if (c == 4) checkOutput("af_gap_busy", 64'(busy), 64'(0));
            if (c == 5) checkOutput("af_next_gid", 64'(grant_id), 64'(3));
            tick();
        end
        checkOutput("af_req2_writes", 64'(wr_cnt), 64'(3));

        $display("[TB] fifo_enable low mid-burst");
        doReset("rst4");
        wr_cnt = 0;
        for (int c = 0; c < 13; c++) begin
            applyStimulus(4'b0001, 4'b0000, !(c >= 3 && c <= 6), 1'b0, 1'b0);
            #3;
            modelCheck($sformatf("en_c%0d", c));
            if (c >= 3 && c <= 6) begin
                checkOutput($sformatf("en_c%0d_wr_en", c), 64'(wr_en), 64'(0));
                checkOutput($sformatf("en_c%0d_gid", c), 64'(grant_id), 64'(0));
            end
            if (wr_en) wr_cnt++;
            tick();
        end
        checkOutput("en_total_writes", 64'(wr_cnt), 64'(8));

        $display("[TB] reset at beat 4");
        doReset("rst5");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
            #3;
            modelCheck($sformatf("mr_c%0d", c));
            tick();
        end
        #3;
        checkOutput("mr_beat4_wr_en", 64'(wr_en), 64'(1));
        wr_rst_n = 1'b0;
        #1;
        checkResetOutputs("mr_abort");
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
        modelReset();
        wr_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
            #3;
            modelCheck($sformatf("mr_post_c%0d", c));
            if (c == 1) checkOutput("mr_post_gid", 64'(grant_id), 64'(0));
            if (wr_en) wr_cnt++;
            tick();
        end
        checkOutput("mr_post_writes", 64'(wr_cnt), 64'(8));

        $display("[TB] randomized traffic");
        doReset("rst6");
        for (int c = 0; c < 600; c++) begin
            rl = '0;
            for (int b = 0; b < N; b++) rl[b] = ($urandom_range(5) == 0);
            applyStimulus(N'($urandom()), rl, ($urandom_range(7) != 0),
                          ($urandom_range(5) == 0), ($urandom_range(9) == 0));
            req_data = (N*DW)'({$urandom(), $urandom()});
            #3;
            modelCheck($sformatf("rnd_c%0d", c));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the async FIFO's write side among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a bounded burst, drives wr_en/wr_data/wr_mask into the FIFO, and applies backpressure from fifo_full, fifo_almost_full and fifo_enable. It sits directly in front of the FIFO write port.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 12, FIFO word width
- MAX_BURST, 8, maximum beats per grant (1..255)

- wr_clk  in  1  write-domain clock; sole clock
- wr_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks the final word of a requester's packet
- req_ready  out  NUM_REQ  one-hot-or-zero accept strobe
- fifo_enable  in  1  global enable; 0 stalls all writes
- fifo_full  in  1  FIFO full flag (write domain)
- fifo_almost_full  in  1  FIFO almost-full flag
- wr_en  out  1  FIFO write strobe
- wr_data  out  DATA_WIDTH  FIFO write data
- wr_mask  out  DATA_WIDTH  write mask; all ones when wr_en=1, else 0
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- busy  out  1  1 while in BURST

## Operation
- Two states: ARB and BURST. Reset enters ARB.
- ARB: if fifo_enable=1 and any req_valid=1, select the first valid index after rr_ptr (wrapping modulo NUM_REQ). Register grant_id, set rr_ptr=grant_id, clear beat_cnt, and go to BURST. No write occurs in ARB.
- BURST: xfer = req_valid[grant_id] & fifo_enable & ~fifo_full.
  - req_ready[grant_id]=xfer; all other ready bits are 0.
  - wr_en=xfer; wr_data=req_data slice of grant_id.
- On each xfer, beat_cnt increments. The burst ends (next state ARB) on an xfer with any of:
  - req_last=1
  - beat_cnt+1 == MAX_BURST
  - fifo_almost_full=1
- req_valid[grant_id] dropping mid-burst does not end the burst; the grant is held until a terminating beat.
- fifo_enable=0 or fifo_full=1 stalls in BURST; the grant, beat_cnt and state are unchanged.
- beat_cnt width is $clog2(MAX_BURST+1) and never exceeds MAX_BURST-1 in the registered state.
- Round-robin wrap: after granting NUM_REQ-1, index 0 has highest priority.

## Timing
- Reset values (async, immediate): state=ARB, rr_ptr=NUM_REQ-1 (so requester 0 wins first), grant_id=0, beat_cnt=0, busy=0. Consequently req_ready=0, wr_en=0, wr_data=0, wr_mask=0.
- wr_en, wr_data, wr_mask and req_ready are combinational from registered state and current inputs: zero-cycle latency from req_valid to wr_en within BURST.
- Grant latency: req_valid asserted in cycle N while in ARB gives busy=1 in N+1, with the first write possible in N+1.
- Every burst is followed by exactly one ARB cycle, so the minimum gap between bursts is one cycle.
- Simultaneous requests are resolved only by rr_ptr order.
- Reset asserted mid-burst aborts the burst immediately. No partial-state recovery is attempted; the requester sees req_ready fall and must re-present the word.
- fifo_full rising in the same cycle as a would-be xfer blocks that beat; the word is held by the requester (valid/ready handshake).

## Test plan
- Reset release, req_valid=4'b0001, 3 words with req_last on the 3rd: wr_en high 3 consecutive cycles starting 1 cycle after request, busy falls after 3rd beat, grant_id=0.
- All four requesters continuously valid, MAX_BURST=8, no last: grants in order 0,1,2,3,0. Each burst is exactly 8 writes separated by a 1-cycle gap.
- Requester 1 bursting, fifo_full=1 for 5 cycles after beat 2: wr_en=0 and req_ready=0 for those 5 cycles, then beats 3..8 complete, total 8 writes, no word lost or duplicated.
- fifo_almost_full=1 asserted at beat 3 of requester 2: burst ends after beat 3 and grant moves to requester 3 (if valid) after 1 ARB cycle.
- fifo_enable=0 mid-burst for 4 cycles: no writes, grant_id unchanged. Writes resume when fifo_enable=1.
- wr_rst_n pulsed low at beat 4 of a burst: outputs drop to 0 immediately. After release, requester 0 wins first and beat_cnt restarts at 0.
